weight_loader: RTL and testbench

//  Initiator side of the weight_storage write port. Accepts a stream of data_size-bit weight

---
 rtl/weight_pkg.sv | 16 +
 rtl/row_packer.sv | 63 ++++++
 rtl/weight_loader.sv | 150 +++++++++++++++
 tb/tb_weight_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// weight_pkg
//   Types and constants shared by the weight loader and the weight storage it feeds.
//   loader_state_t : FSM states of weight_loader
//   INDEX_W        : width of the layer/row index ports on the storage write interface
package weight_pkg;

  localparam int INDEX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/row_packer.sv
// row_packer
//   Collects `size` words of data_size bits into one packed row. Column 0 (the first
//   word of a row) lands in the most significant slice.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clear       drop any partially collected row and restart at column 0
//     accept      a word is taken this cycle
//     word        the incoming word
//     row_next    packed row including this cycle's word (combinational view of the
//                 slots after the accept), so the caller can register a complete row on
//                 the same edge that takes its last word
//     row_full    this cycle's accept completes the row
module row_packer #(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [data_size-1:0]        word,
  output logic [data_size*size-1:0]   row_next,
  output logic                        row_full
);

  localparam int COL_W = (size > 1) ? $clog2(size) : 1;

  logic [COL_W-1:0]     col_reg;
  logic [data_size-1:0] slot_reg [size];

  assign row_full = accept && (col_reg == COL_W'(size - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
    end else if (clear) begin
      col_reg <= '0;
    end else if (accept) begin
      col_reg <= row_full ? '0 : col_reg + COL_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_slot
      logic hit;
      assign hit = accept && (col_reg == COL_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= '0;
        end else if (clear) begin
          slot_reg[gi] <= '0;
        end else if (hit) begin
          slot_reg[gi] <= word;
        end
      end

      assign row_next[(size-gi)*data_size-1 -: data_size] = hit ? word : slot_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/weight_loader.sv
// weight_loader
//   Initiator side of the weight_storage write port. Takes a valid/ready stream of
//   weight words, packs `size` words per row and issues a one-cycle is_write per row,
//   walking layer-major then row. Pulses done after the last row of the last layer.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     start                              begin a full load (only honoured in IDLE)
//     in_data, in_valid, in_ready        word stream handshake
//     write_layer_index, write_row_index target row for the current write
//     write_data                         packed row (first word in the MSB slice)
//     is_write                           one-cycle write strobe
//     busy                               high from start acceptance until done
//     done                               one-cycle pulse after the final row write
//     checksum                           running sum of accepted words (optional)
//   Build option: define WEIGHT_LOADER_CHECKSUM_EN to enable the checksum
//   accumulator; otherwise checksum is tied to 0.
module weight_loader
  import weight_pkg::*;
#(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int layer_size = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [data_size-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [INDEX_W-1:0]         write_layer_index,
  output logic [INDEX_W-1:0]         write_row_index,
  output logic [data_size*size-1:0]  write_data,
  output logic                       is_write,
  output logic                       busy,
  output logic                       done,
  output logic [data_size-1:0]       checksum
);

  loader_state_t state_reg, state_next;

  logic [INDEX_W-1:0]        row_cnt_reg;
  logic [INDEX_W-1:0]        layer_cnt_reg;
  logic                      accept;
  logic                      start_accept;
  logic                      last_row;
  logic                      row_full;
  logic [data_size*size-1:0] row_next;

  // in_ready is a registered copy of (state == LOAD), so gating with it is exact.
  assign accept       = in_valid && in_ready;
  assign start_accept = (state_reg == IDLE) && start;
  assign last_row     = (layer_cnt_reg == INDEX_W'(layer_size - 1)) &&
                        (row_cnt_reg   == INDEX_W'(size - 1));

  row_packer #(
    .data_size (data_size),
    .size      (size)
  ) u_row_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_accept),
    .accept   (accept),
    .word     (in_data),
    .row_next (row_next),
    .row_full (row_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = LOAD;
      LOAD:    if (row_full) state_next = WRITE;
      WRITE:   state_next = last_row ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/strobe outputs are registered decodes of the next state, so they line
  // up with the state they describe and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      is_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_next == LOAD);
      is_write <= (state_next == WRITE);
      busy     <= (state_next == LOAD) || (state_next == WRITE);
      done     <= (state_next == DONE);
    end
  end

  // The completed row and its indices are captured on the edge that takes the last
  // word, so they are already valid in the cycle is_write is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_data        <= '0;
      write_layer_index <= '0;
      write_row_index   <= '0;
    end else if (row_full) begin
      write_data        <= row_next;
      write_layer_index <= layer_cnt_reg;
      write_row_index   <= row_cnt_reg;
    end
  end

  // Counters advance as each WRITE retires. After the final row the layer counter
  // steps past the end; that value is never observed and start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_reg   <= '0;
      layer_cnt_reg <= '0;
    end else if (start_accept) begin
      row_cnt_reg   <= '0;
      layer_cnt_reg <= '0;
    end else if (state_reg == WRITE) begin
      if (row_cnt_reg == INDEX_W'(size - 1)) begin
        row_cnt_reg   <= '0;
        layer_cnt_reg <= layer_cnt_reg + INDEX_W'(1);
      end else begin
        row_cnt_reg   <= row_cnt_reg + INDEX_W'(1);
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_accept) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
`timescale 1ns/1ps
module tb_weight_loader;

  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int LS = 5;
  localparam int NROWS = SZ * LS;
  localparam int NWORDS = NROWS * SZ;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DS-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       write_layer_index;
  logic [31:0]       write_row_index;
  logic [DS*SZ-1:0]  write_data;
  logic              is_write;
  logic              busy;
  logic              done;
  logic [DS-1:0]     checksum;

  weight_loader #(.data_size(DS), .size(SZ), .layer_size(LS)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .write_layer_index (write_layer_index),
    .write_row_index   (write_row_index),
    .write_data        (write_data),
    .is_write          (is_write),
    .busy              (busy),
    .done              (done),
    .checksum          (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write/done monitor; samples on the falling edge, away from the active edge.
  int          cycle = 0;
  int          nw = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [DS-1:0] done_sum = '0;
  logic        done_busy = 1'b0;
  logic [31:0] wr_layer [128];
  logic [31:0] wr_row   [128];
  logic [DS*SZ-1:0] wr_data [128];
  int          wr_cyc   [128];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (is_write && nw < 128) begin
      wr_layer[nw] = write_layer_index;
      wr_row[nw]   = write_row_index;
      wr_data[nw]  = write_data;
      wr_cyc[nw]   = cycle;
      $display("write layer=%0d row=%0d data=%h", write_layer_index, write_row_index, write_data);
      nw++;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cycle;
      done_sum  = checksum;
      done_busy = busy;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed n words base, base+1, ... ; toggle=1 drives in_valid only every other cycle.
  task automatic feed(input int base, input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = DS'(base + idx);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("feed_accepted", 64'(idx), 64'(n));
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  // 15 writes starting at record first, words base.. in layer/row order.
  task automatic check_run(input int first, input int base, input bit spacing);
    logic [DS*SZ-1:0] exp_row;
    check("write_count", 64'(nw - first), 64'(NROWS));
    for (int r = 0; r < NROWS && first + r < nw; r++) begin
      exp_row = {DS'(base + 3*r), DS'(base + 3*r + 1), DS'(base + 3*r + 2)};
      check($sformatf("layer_%0d", r), 64'(wr_layer[first+r]), 64'(r / SZ));
      check($sformatf("row_%0d", r),   64'(wr_row[first+r]),   64'(r % SZ));
      check($sformatf("data_%0d", r),  64'(wr_data[first+r]),  64'(exp_row));
      if (spacing && r > 0)
        check($sformatf("spacing_%0d", r), 64'(wr_cyc[first+r] - wr_cyc[first+r-1]), 64'(SZ + 1));
    end
    if (nw - first == NROWS)
      check("done_latency", 64'(done_cyc - wr_cyc[first+NROWS-1]), 64'd1);
    check("busy_at_done", 64'(done_busy), 64'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd0);
    check({pfx, "_is_write"}, 64'(is_write), 64'd0);
    check({pfx, "_busy"},     64'(busy), 64'd0);
    check({pfx, "_done"},     64'(done), 64'd0);
    check({pfx, "_wdata"},    64'(write_data), 64'd0);
    check({pfx, "_wlayer"},   64'(write_layer_index), 64'd0);
    check({pfx, "_wrow"},     64'(write_row_index), 64'd0);
    check({pfx, "_csum"},     64'(checksum), 64'd0);
  endtask

  initial begin
    int first;
    int d0;
    logic [DS-1:0] exp_sum;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    exp_sum = 16'h040B;
`else
    exp_sum = 16'h0000;
`endif

    // Power-on reset.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream 1..45.
    first = nw; d0 = done_cnt;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    feed(1, NWORDS, 1'b0);
    wait_done(d0);
    check_run(first, 1, 1'b1);
    check("checksum", 64'(done_sum), 64'(exp_sum));
    check("idle_after_done", 64'(busy), 64'd0);

    // Same stream, in_valid toggling.
    first = nw; d0 = done_cnt;
    pulse_start();
    feed(1, NWORDS, 1'b1);
    wait_done(d0);
    check_run(first, 1, 1'b0);
    check("checksum_toggle", 64'(done_sum), 64'(exp_sum));

    // start pulsed while busy after 5 words is ignored.
    first = nw; d0 = done_cnt;
    pulse_start();
    feed(1, 5, 1'b0);
    pulse_start();
    check("busy_ignored_start", 64'(busy), 64'd1);
    feed(6, NWORDS - 5, 1'b0);
    wait_done(d0);
    check_run(first, 1, 1'b0);

    // Reset mid-row after 4 words, then a fresh load of 100..144.
    pulse_start();
    feed(1, 4, 1'b0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    first = nw;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_partial_write", 64'(nw - first), 64'd0);
    first = nw; d0 = done_cnt;
    pulse_start();
    feed(100, NWORDS, 1'b0);
    wait_done(d0);
    check_run(first, 100, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
